// File: rtl/theory_arith_pkg.sv
// Shared definitions for the theory-path sequential arithmetic blocks
// (multiplier and restoring divider).
package theory_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

endpackage

// File: rtl/theory_abs_neg.sv
// Conditional magnitude: returns |val| when en is set and val is negative in
// two's complement, otherwise passes val through. The most negative value maps
// to itself, which is the correct unsigned magnitude.
module theory_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             en,
    output logic [WIDTH-1:0] mag
);

    assign mag = (en && val[WIDTH-1]) ? (~val + 1'b1) : val;

endmodule

// File: rtl/theory_multiplier_32bit.sv
// Sequential shift-add multiplier, one partial product per clock, sign-magnitude
// internally. Load edge E0, 32 iterations on E1..E32, done pulse at E32,
// back in IDLE at E33.
module theory_multiplier_32bit
    import theory_arith_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_sig,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy_sig,
    output logic                 done_sig,
    output logic [2*WIDTH-1:0]   product
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     a_mag, b_mag;

    theory_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .val (multiplicand),
        .en  (SIGNED),
        .mag (a_mag)
    );

    theory_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .val (multiplier),
        .en  (SIGNED),
        .mag (b_mag)
    );

    // Next-state and datapath: load in IDLE, one shift-add step per CALC cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        product_d = product_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // Magnitude product is < 2^64 so this add never overflows.
        acc_next  = acc_q + (mplr_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (start_sig) begin
                    neg_d   = SIGNED & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    mcand_d = {{WIDTH{1'b0}}, a_mag};
                    mplr_d  = b_mag;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_next;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // ~0+1 wraps to 0, so a zero product never comes out negative.
                    product_d = neg_q ? (~acc_next + 1'b1) : acc_next;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_sig = busy_q;
    assign done_sig = done_q;
    assign product  = product_q;

endmodule

// File: tb/tb_theory_multiplier_32bit.sv
// Bench for theory_multiplier_32bit: a signed and an unsigned instance share
// stimulus; a timing/arithmetic model predicts outputs every cycle.
module tb_theory_multiplier_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_sig;
    logic [31:0] a, b;
    logic        busy_s, done_s, busy_u, done_u;
    logic [63:0] prod_s, prod_u;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    theory_multiplier_32bit #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start_sig(start_sig),
        .multiplicand(a), .multiplier(b),
        .busy_sig(busy_s), .done_sig(done_s), .product(prod_s)
    );

    theory_multiplier_32bit #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start_sig(start_sig),
        .multiplicand(a), .multiplier(b),
        .busy_sig(busy_u), .done_sig(done_u), .product(prod_u)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] ref_s(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] xs, ys;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        return 64'(xs * ys);
    endfunction

    function automatic logic [63:0] ref_u(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Model: accept a start only when free; result and done at load+32,
    // free again (busy low) at load+33.
    int          cyc = 0;
    int          m_load = 0;
    bit          m_act = 1'b0;
    bit          exp_busy = 1'b0, exp_done = 1'b0;
    logic [63:0] pend_s = '0, pend_u = '0, exp_ps = '0, exp_pu = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
            exp_ps = '0; exp_pu = '0; cyc = 0;
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (m_act) begin
                if (cyc == m_load + 32) begin
                    exp_done = 1'b1; exp_ps = pend_s; exp_pu = pend_u;
                end else if (cyc == m_load + 33) begin
                    m_act = 1'b0; exp_busy = 1'b0;
                end
            end else if (start_sig) begin
                m_act = 1'b1; m_load = cyc; exp_busy = 1'b1;
                pend_s = ref_s(a, b); pend_u = ref_u(a, b);
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy_s", 64'(busy_s), 64'(exp_busy));
            chk("done_s", 64'(done_s), 64'(exp_done));
            chk("prod_s", prod_s, exp_ps);
            chk("busy_u", 64'(busy_u), 64'(exp_busy));
            chk("done_u", 64'(done_u), 64'(exp_done));
            chk("prod_u", prod_u, exp_pu);
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] es, input logic [63:0] eu,
                          input string nm, input bit poke);
        int lat;
        @(negedge clk);
        a = x; b = y; start_sig = 1'b1;
        @(posedge clk);               // E0
        #1;
        start_sig = 1'b0;
        a = $urandom; b = $urandom;   // operands free after load
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (poke && i == 9)  begin start_sig = 1'b1; a = 32'd11; b = 32'd13; end
            if (poke && i == 10) start_sig = 1'b0;
            if (done_s) lat = i;
        end
        chk({nm, " latency"}, 64'(lat), 64'd32);
        chk({nm, " lit_s"}, prod_s, es);
        chk({nm, " lit_u"}, prod_u, eu);
        @(posedge clk);               // E33
        #1;
    endtask

    initial begin
        int t1, t2;
        rst = 1'b1; start_sig = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst busy_s", 64'(busy_s), 64'd0);
        chk("rst done_s", 64'(done_s), 64'd0);
        chk("rst prod_s", prod_s, 64'd0);
        chk("rst prod_u", prod_u, 64'd0);
        chk_on = 1'b1;
        rst = 1'b0;

        run_op(32'd7,          32'd6,          64'd42,                  64'd42,                  "7x6", 1'b0);
        run_op(32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6, 64'h0000_0005_FFFF_FFD6, "-7x6", 1'b0);
        run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1,                   64'hFFFF_FFFE_0000_0001, "ones", 1'b0);
        run_op(32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, "min*min", 1'b0);
        run_op(32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, "min*1", 1'b0);
        run_op(32'd0,          32'h1234_5678,  64'd0,                   64'd0,                   "zero", 1'b0);
        run_op(32'd0,          32'hFFFF_FFFF,  64'd0,                   64'd0,                   "negzero", 1'b0);
        run_op(32'd1000,       32'd3000,       64'd3000000,             64'd3000000,             "poke", 1'b1);

        // Held start: two back-to-back results 34 clocks apart.
        @(negedge clk);
        a = 32'd100; b = 32'd200; start_sig = 1'b1;
        t1 = 0; t2 = 0;
        for (int i = 1; i <= 100 && t2 == 0; i++) begin
            @(negedge clk);
            if (done_s) begin
                if (t1 == 0) begin
                    t1 = i;
                    chk("held first", prod_s, 64'd20000);
                    a = 32'd7; b = 32'hFFFF_FFFD;
                end else begin
                    t2 = i;
                    start_sig = 1'b0;
                end
            end
        end
        chk("held spacing", 64'(t2 - t1), 64'd34);
        chk("held second s", prod_s, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("held second u", prod_u, 64'h0000_0006_FFFF_FFEB);
        @(posedge clk);
        #1;

        // Mid-operation async reset at E15.
        @(negedge clk);
        a = 32'd9; b = 32'd9; start_sig = 1'b1;
        @(posedge clk);
        #1;
        start_sig = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy_s", 64'(busy_s), 64'd0);
        chk("abort done_s", 64'(done_s), 64'd0);
        chk("abort prod_s", prod_s, 64'd0);
        chk("abort prod_u", prod_u, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd3, 32'd5, 64'd15, 64'd15, "post-rst", 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
